// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Merges ALU results and FIFO-buffered load results onto a single
//               register-file write port, with an anti-starvation counter.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [3:0]  pend_count
);

    localparam int         C_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_DEPTH = 4'(DEPTH);

    logic [4:0]      r_addr_mem [DEPTH];
    logic [31:0]     r_data_mem [DEPTH];
    logic [C_AW-1:0] r_wptr;
    logic [C_AW-1:0] r_rptr;
    logic [3:0]      r_count;
    logic [1:0]      r_starve;

    logic        w_empty;
    logic        w_alu_acc;
    logic        w_push;
    logic        w_pop;
    logic        w_sel_valid;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;

    assign w_empty   = (r_count == 4'd0);
    // Full check uses the registered count only, so a same-cycle pop never frees a slot.
    assign mem_ready = (r_count < C_DEPTH);
    assign alu_ready = !((r_starve == 2'd3) && !w_empty);
    assign w_alu_acc = alu_valid && alu_ready;
    assign w_push    = mem_valid && mem_ready;
    assign w_pop     = !w_alu_acc && !w_empty;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_addr  = 5'd0;
        w_sel_data  = 32'd0;
        if (w_alu_acc) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = alu_waddr;
            w_sel_data  = alu_wdata;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = r_addr_mem[r_rptr];
            w_sel_data  = r_data_mem[r_rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_addr_mem[r_wptr] <= mem_waddr;
            r_data_mem[r_wptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= 4'd0;
            r_starve <= 2'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + C_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + C_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (w_pop || w_empty)
                r_starve <= 2'd0;
            else if (w_alu_acc && (r_starve != 2'd3))
                r_starve <= r_starve + 2'd1;
        end
    end

    // Writes to r0 still use their slot but are suppressed; address/data hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= 5'd0;
            wdata <= 32'd0;
        end else begin
            we <= w_sel_valid && (w_sel_addr != 5'd0);
            if (w_sel_valid && (w_sel_addr != 5'd0)) begin
                waddr <= w_sel_addr;
                wdata <= w_sel_data;
            end
        end
    end

    assign pend_count = r_count;

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: number of entries in the load-result FIFO; legal values 2, 4, 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_valid  input  1  ALU result offered this cycle.
REQ-005 alu_ready  output  1  combinational; ALU result accepted when alu_valid && alu_ready.
REQ-006 alu_waddr  input  5  destination register of ALU result.
REQ-007 alu_wdata  input  32  ALU result data.
REQ-008 mem_valid  input  1  load result offered this cycle.
REQ-009 mem_ready  output  1  FIFO can accept; load accepted when mem_valid && mem_ready.
REQ-010 mem_waddr  input  5  destination register of load result.
REQ-011 mem_wdata  input  32  load result data.
REQ-012 we  output  1  registered write enable to the register-file write port.
REQ-013 waddr  output  5  registered write address to the register-file write port.
REQ-014 wdata  output  32  registered write data to the register-file write port.
REQ-015 pend_count  output  4  registered number of valid FIFO entries (0..DEPTH).

Function
REQ-016 The block SHALL issue at most one register-file write per cycle, merging ALU and load results onto the single write port.
REQ-017 mem_ready SHALL equal (pend_count < DEPTH), using the registered count only; no push on full, even with a same-cycle pop.
REQ-018 An accepted load SHALL be pushed into the FIFO at the accepting edge; no bypass: minimum load-to-we latency is 2 cycles.
REQ-019 An accepted ALU result SHALL appear on we/waddr/wdata exactly 1 cycle after acceptance.
REQ-020 Arbitration each cycle: if ALU accepted, ALU wins; else if FIFO non-empty, pop the head to the output; else we=0 next cycle.
REQ-021 Starvation counter starve_cnt (2 bits) SHALL increment when ALU wins while the FIFO is non-empty, clear on any FIFO pop or when the FIFO is empty, and saturate at 3.
REQ-022 alu_ready SHALL be 0 exactly when starve_cnt==3 and the FIFO is non-empty; that cycle the FIFO head is popped.
REQ-023 Push and pop on the same edge SHALL leave pend_count unchanged and preserve FIFO order; FIFO order is strict first-in first-out.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; pend_count SHALL never exceed DEPTH nor underflow.
REQ-025 A write with address 0 SHALL still be accepted and consume its arbitration slot, but SHALL drive we=0 in its output cycle.
REQ-026 When we=0, waddr and wdata SHALL hold their previous values.
REQ-027 Writes SHALL reach the port in arbitration order; no reordering or merging of same-address writes.

Reset
REQ-028 While rst=1: we=0, waddr=0, wdata=0, pend_count=0, pointers=0, starve_cnt=0, FIFO contents discarded.
REQ-029 Reset mid-operation SHALL drop all pending loads and any in-flight output write; the first write-port activity after rst falls SHALL come from a transaction accepted after reset.
REQ-030 Outputs during reset: mem_ready=1; alu_ready=1.

Verification
REQ-031 Idle load: mem_valid=1, waddr=5, wdata=0x1234 at cycle 0, no ALU traffic -> we=1, waddr=5, wdata=0x1234 at cycle 2; pend_count 1 at cycle 1, then 0.
REQ-032 Full FIFO: DEPTH=4, alu_valid held 1, 5 loads offered back-to-back -> mem_ready=0 once pend_count=4; no fifth push until a pop occurs.
REQ-033 Starvation: FIFO holds 1 entry, alu_valid held 1 -> ALU wins 3 cycles; 4th cycle alu_ready=0 and the load is written; afterwards alu_ready=1.
REQ-034 Simultaneous push/pop: pend_count=2, load accepted while head pops -> pend_count stays 2; popped data are the entries in push order.
REQ-035 Zero address: ALU write to r0 with data 0xFFFFFFFF -> we=0 next cycle, waddr/wdata unchanged.
REQ-036 Async reset: assert rst between clock edges with pend_count=3 -> we, pend_count immediately 0; after release no stale load is written.
